// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: accepts the write stream, drives the RAM
// write port, keeps the binary write pointer and derives level/full flags plus flush handshake.
module fifo_wr_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk_snd,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_rdy,
  input  logic [ADDR_W:0]       rd_ptr_sync,
  output logic [ADDR_W:0]       wr_ptr_bin,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_W:0]       level,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  ptr_err,
  input  logic                  flush_req,
  output logic                  flush_ack
);

  localparam int             DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_V    = (ADDR_W+1)'(AF_LEVEL);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [ADDR_W:0] r_wr_ptr;
  logic            r_overflow;
  logic            r_ptr_err;
  logic            r_flush_ack;

  logic [ADDR_W:0] w_level;
  logic            w_full;
  logic            w_level_bad;
  logic            w_wr_rdy;
  logic            w_accept;

  // Extra pointer MSB lets a wrapping subtraction tell full (DEPTH) from empty (0).
  assign w_level     = r_wr_ptr - rd_ptr_sync;
  assign w_full      = (w_level == DEPTH_V);
  assign w_level_bad = (w_level > DEPTH_V);

  assign w_wr_rdy = (r_state == S_RUN) & ~w_full & ~r_ptr_err;
  assign w_accept = wr_req & w_wr_rdy;

  assign wr_rdy      = w_wr_rdy;
  assign wr_ptr_bin  = r_wr_ptr;
  assign mem_we      = w_accept;
  assign mem_waddr   = r_wr_ptr[ADDR_W-1:0];
  assign mem_wdata   = wr_data;
  assign level       = w_level;
  assign full        = w_full;
  assign almost_full = (w_level >= AF_V);
  assign overflow    = r_overflow;
  assign ptr_err     = r_ptr_err;
  assign flush_ack   = r_flush_ack;

  always_ff @(posedge clk_snd or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_wr_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_ptr_err   <= 1'b0;
      r_flush_ack <= 1'b0;
    end else begin
      // +1 only, so the gray-coded copy crossing domains flips a single bit per step.
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      // Refused writes only count as overflow while running; a drain refuses silently.
      if ((r_state == S_RUN) && wr_req && !w_wr_rdy) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end

      if (w_level_bad) begin
        r_ptr_err <= 1'b1;
      end

      case (r_state)
        S_RUN: begin
          if (flush_req) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_level == '0) begin
            r_state     <= S_DONE;
            r_flush_ack <= 1'b1;
          end
        end
        S_DONE: begin
          if (!flush_req) begin
            r_state     <= S_RUN;
            r_flush_ack <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_RUN;
          r_flush_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: a vector table for fill/overflow, then hand sequences
// for pointer wrap, flush handshake, async reset and corrupt reader pointer.
module tb_fifo_wr_ctrl;

  logic        clk_snd;
  logic        rst;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        wr_rdy;
  logic [4:0]  rd_ptr_sync;
  logic [4:0]  wr_ptr_bin;
  logic        mem_we;
  logic [3:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [4:0]  level;
  logic        full;
  logic        almost_full;
  logic        overflow;
  logic        ovf_clr;
  logic        ptr_err;
  logic        flush_req;
  logic        flush_ack;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_ctrl #(.DATA_WIDTH(32), .ADDR_W(4), .AF_LEVEL(12)) dut (
    .clk_snd    (clk_snd),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_rdy     (wr_rdy),
    .rd_ptr_sync(rd_ptr_sync),
    .wr_ptr_bin (wr_ptr_bin),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .level      (level),
    .full       (full),
    .almost_full(almost_full),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .ptr_err    (ptr_err),
    .flush_req  (flush_req),
    .flush_ack  (flush_ack)
  );

  initial begin
    clk_snd = 1'b0;
    forever #5 clk_snd = ~clk_snd;
  end

  typedef struct {
    logic        req;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        clr;
    logic        e_rdy;
    logic        e_we;
    logic [3:0]  e_waddr;
    logic [4:0]  e_ptr;
    logic [4:0]  e_level;
    logic        e_full;
    logic        e_af;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic next_cycle();
    @(negedge clk_snd);
  endtask

  logic [4:0] m_ptr;
  logic [4:0] lag[3];
  logic [4:0] prev_ptr;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill with rd=0, then overflow / set-beats-clear, then reader catches up.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{req: 1'b1, data: 32'hA000 + i, rd: 5'd0, clr: 1'b0,
                  e_rdy: 1'b1, e_we: 1'b1, e_waddr: 4'(i), e_ptr: 5'(i), e_level: 5'(i),
                  e_full: 1'b0, e_af: (i >= 12), e_ovf: 1'b0};
    end
    vecs[16] = '{1'b1, 32'hBAD0, 5'd0,  1'b0, 1'b0, 1'b0, 4'd0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 32'hBAD1, 5'd0,  1'b1, 1'b0, 1'b0, 4'd0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 32'h0,    5'd0,  1'b1, 1'b0, 1'b0, 4'd0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 32'h0,    5'd0,  1'b0, 1'b0, 1'b0, 4'd0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 32'h0,    5'd16, 1'b0, 1'b1, 1'b0, 4'd0, 5'd16, 5'd0,  1'b0, 1'b0, 1'b0};

    rst = 1'b0; wr_req = 1'b0; wr_data = '0; rd_ptr_sync = '0; ovf_clr = 1'b0; flush_req = 1'b0;
    #2;
    check("reset_ptr", 32'(wr_ptr_bin), 32'd0);
    check("reset_flags", {overflow, ptr_err, flush_ack, mem_we, full}, 5'b00000);
    check("reset_rdy_level", {wr_rdy, level}, {1'b1, 5'd0});
    next_cycle();
    next_cycle();
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      next_cycle();
      wr_req = vecs[i].req; wr_data = vecs[i].data; rd_ptr_sync = vecs[i].rd; ovf_clr = vecs[i].clr;
      #2;
      check($sformatf("vec%0d_ptr", i), 32'(wr_ptr_bin), 32'(vecs[i].e_ptr));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_level));
      check($sformatf("vec%0d_flags(rdy,we,full,af,ovf)", i),
            {wr_rdy, mem_we, full, almost_full, overflow},
            {vecs[i].e_rdy, vecs[i].e_we, vecs[i].e_full, vecs[i].e_af, vecs[i].e_ovf});
      if (vecs[i].e_we) begin
        check($sformatf("vec%0d_waddr", i), 32'(mem_waddr), 32'(vecs[i].e_waddr));
        check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].data);
      end
    end
    ovf_clr = 1'b0;

    // Wrap: reader follows with a 3-cycle lag over 40 writes (pointer 16 -> 24 through 31->0).
    m_ptr = 5'd16;
    for (int i = 0; i < 3; i++) lag[i] = 5'd16;
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      rd_ptr_sync = lag[0]; wr_req = 1'b1; wr_data = 32'hC000 + k;
      #2;
      check($sformatf("wrap%0d_ptr", k), 32'(wr_ptr_bin), 32'(m_ptr));
      check($sformatf("wrap%0d_level", k), 32'(level), 32'(5'(m_ptr - lag[0])));
      check($sformatf("wrap%0d_level_le_depth", k), 32'(level <= 5'd16), 32'd1);
      check($sformatf("wrap%0d_we_addr", k), {mem_we, mem_waddr}, {1'b1, m_ptr[3:0]});
      prev_ptr = wr_ptr_bin;
      @(posedge clk_snd);
      #1;
      check($sformatf("wrap%0d_gray_bits", k), $countones(gray(prev_ptr) ^ gray(wr_ptr_bin)), 32'd1);
      lag[0] = lag[1]; lag[1] = lag[2]; lag[2] = m_ptr;
      m_ptr = m_ptr + 5'd1;
    end
    next_cycle();
    wr_req = 1'b0; rd_ptr_sync = 5'd24;
    #2;
    check("wrap_end_ptr", 32'(wr_ptr_bin), 32'd24);
    check("wrap_end_level", 32'(level), 32'd0);

    // Flush: level 5, drain via reader, ack, release.
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      wr_req = 1'b1; wr_data = 32'hD000 + k;
    end
    next_cycle();
    wr_req = 1'b0; flush_req = 1'b1;
    #2;
    check("flush_start_level", 32'(level), 32'd5);
    check("flush_start_rdy", 32'(wr_rdy), 32'd1);
    next_cycle();
    wr_req = 1'b1;
    #2;
    check("drain_rdy_we_ack", {wr_rdy, mem_we, flush_ack}, 3'b000);
    next_cycle();
    wr_req = 1'b0;
    #2;
    check("drain_no_ovf", {overflow, level}, {1'b0, 5'd5});
    for (int j = 1; j <= 5; j++) begin
      next_cycle();
      rd_ptr_sync = 5'(24 + j);
      #2;
      check($sformatf("drain_step%0d_ack", j), 32'(flush_ack), 32'd0);
    end
    next_cycle();
    #2;
    check("done_ack_rdy", {flush_ack, wr_rdy}, 2'b10);
    flush_req = 1'b0;
    #1;
    check("done_ack_held", 32'(flush_ack), 32'd1);
    next_cycle();
    #2;
    check("flush_release", {flush_ack, wr_rdy}, 2'b01);

    // flush_req dropped during DRAIN still yields a single-cycle ack.
    next_cycle();
    wr_req = 1'b1; wr_data = 32'hE000;
    next_cycle();
    wr_req = 1'b0; flush_req = 1'b1;
    #2;
    check("short_flush_level", 32'(level), 32'd1);
    next_cycle();
    flush_req = 1'b0;
    #2;
    check("short_drain_rdy", 32'(wr_rdy), 32'd0);
    next_cycle();
    rd_ptr_sync = 5'd30;
    #2;
    check("short_drain_ack0", 32'(flush_ack), 32'd0);
    next_cycle();
    #2;
    check("short_done_ack1", 32'(flush_ack), 32'd1);
    next_cycle();
    #2;
    check("short_back_run", {flush_ack, wr_rdy}, 2'b01);

    // Async reset mid-burst at level 9.
    for (int k = 0; k < 9; k++) begin
      next_cycle();
      wr_req = 1'b1; wr_data = 32'hF000 + k;
    end
    next_cycle();
    #2;
    check("burst_level", 32'(level), 32'd9);
    #1;
    rst = 1'b0; wr_req = 1'b0; rd_ptr_sync = 5'd0;
    #1;
    check("async_rst_ptr", 32'(wr_ptr_bin), 32'd0);
    check("async_rst_flags", {overflow, ptr_err, flush_ack, mem_we, full, level}, {5'b00000, 5'd0});
    next_cycle();
    rst = 1'b1;

    // Corrupt pointer: level 14 is legal, level 17 latches ptr_err until reset.
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      wr_req = 1'b1; wr_data = 32'h1000 + k;
    end
    next_cycle();
    wr_req = 1'b0; rd_ptr_sync = 5'd20;
    #2;
    check("corrupt_ptr", 32'(wr_ptr_bin), 32'd2);
    check("corrupt_level14", 32'(level), 32'd14);
    next_cycle();
    #2;
    check("level14_no_err", {ptr_err, wr_rdy}, 2'b01);
    rd_ptr_sync = 5'd17;
    #1;
    check("corrupt_level17", 32'(level), 32'd17);
    next_cycle();
    wr_req = 1'b1;
    #2;
    check("ptr_err_set", {ptr_err, wr_rdy, mem_we}, 3'b100);
    next_cycle();
    wr_req = 1'b0; rd_ptr_sync = 5'd2;
    #2;
    check("ptr_err_sticky", {ptr_err, wr_rdy, level}, {2'b10, 5'd0});
    check("ptr_err_no_write", 32'(wr_ptr_bin), 32'd2);
    rst = 1'b0;
    #1;
    check("ptr_err_reset", 32'(ptr_err), 32'd0);
    next_cycle();
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Write-side pointer/flag controller for the async FIFO. Runs entirely in the sender clock domain.
- Accepts a valid/ready write stream and drives the dual-port RAM write port.
- Keeps the binary write pointer; feeds it to the gray-code pointer synchronizer toward the reader domain.
- Computes full/almost_full/level from the reader pointer that has already been synchronized back into this domain. Adds sticky overflow/pointer-error flags and a 4-phase flush (drain) handshake.

Parameters:
- DATA_WIDTH, 32, payload width.
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W entries.
- AF_LEVEL, 12, almost_full threshold in entries (1..DEPTH).

Ports:
- clk_snd  in  1  write-domain clock.
- rst  in  1  asynchronous active-low reset.
- wr_req  in  1  write request (valid).
- wr_data  in  DATA_WIDTH  write payload.
- wr_rdy  out  1  write may be accepted this cycle.
- rd_ptr_sync  in  ADDR_W+1  binary reader pointer, already synchronized into clk_snd.
- wr_ptr_bin  out  ADDR_W+1  registered binary write pointer, to synchronizer bin_in.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  ADDR_W  RAM write address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- level  out  ADDR_W+1  fill level seen from write side.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AF_LEVEL.
- overflow  out  1  sticky: write attempted while not ready.
- ovf_clr  in  1  clears overflow.
- ptr_err  out  1  sticky: level > DEPTH (corrupt pointer); cleared only by reset.
- flush_req  in  1  drain request, 4-phase.
- flush_ack  out  1  drain complete.

Behaviour:
- Reset (rst=0, async): wr_ptr_bin=0, state=RUN, overflow=0, ptr_err=0, flush_ack=0.
  - Combinational outputs follow from that state: level=rd-dependent, mem_we=0 (wr_req is don't-care until the first edge).
- Level and flags:
  - level = (wr_ptr_bin - rd_ptr_sync) mod 2**(ADDR_W+1). Unsigned wrap subtraction; MSB distinguishes full from empty.
  - full and almost_full are combinational from level.
  - The value is conservative, because rd_ptr_sync lags the reader.
- Ready/accept:
  - wr_rdy = (state==RUN) & ~full & ~ptr_err. There is no combinational path from wr_req to wr_rdy.
  - Accept = wr_req & wr_rdy. On accept, in the same cycle (combinational): mem_we=1, mem_waddr=wr_ptr_bin[ADDR_W-1:0], mem_wdata=wr_data.
  - On the clock edge after accept, wr_ptr_bin += 1, wrapping at 2**(ADDR_W+1). The RAM write and the pointer update occur on the same edge.
  - Zero latency from request to write; the pointer is visible at the synchronizer input 1 cycle later.
  - Increment is +1 only, so the gray encoding changes exactly 1 bit.
- Overflow:
  - Set on wr_req & ~wr_rdy while state==RUN.
  - Not set in DRAIN/DONE; writes there are silently refused.
  - ovf_clr clears it. If set and clear occur in the same cycle, set wins.
- ptr_err: set when level > DEPTH. While set, all writes are blocked.
- Flush FSM:
  - RUN: flush_req=1 moves to DRAIN. A write accepted in that same cycle still completes.
  - DRAIN: wr_rdy=0. Waits for level==0, then moves to DONE.
  - DONE: flush_ack=1 (registered). Stays until flush_req=0, then returns to RUN with flush_ack=0 on the next edge.
  - If flush_req drops during DRAIN: continue to DONE, emit a 1-cycle flush_ack, then return to RUN.
- Wrap: pointer 31→0 (ADDR_W=4). Level math must remain correct across the wrap.
- Reset mid-operation: all state is cleared immediately. The reader side must be reset together.

Test Plan:
- Fill: rd_ptr_sync=0, 16 back-to-back wr_req → mem_waddr 0..15, wr_ptr_bin=16, full=1, wr_rdy=0, almost_full rises at level=12.
- Overflow: at full, wr_req for 1 cycle → mem_we=0, overflow=1. Next cycle ovf_clr=1 with wr_req=1 → overflow stays 1. Then ovf_clr alone → overflow=0.
- Wrap: rd_ptr_sync follows with 3-cycle lag over 40 writes → wr_ptr_bin 31→0, level never >16, every consecutive pointer pair differs by 1 gray bit.
- Flush: level=5, flush_req=1 → wr_rdy=0 next cycle. rd_ptr_sync advances by 5 → flush_ack=1 one cycle after level=0. Drop flush_req → RUN, wr_rdy=1.
- Corrupt pointer: wr_ptr_bin=2, drive rd_ptr_sync=20 (level=14 legal); then rd_ptr_sync=17 (level=17) → ptr_err=1, wr_rdy=0 until reset.
- Async reset mid-burst at level=9 → all outputs at reset values immediately, without waiting for a clk_snd edge.
